core_seq: RTL
=============

CORE_SEQ -- requirements
Module: core_seq

Interface
REQ-001 Parameter PCW, default 10, program counter width.
REQ-002 Parameter IW, default 9, instruction width.
REQ-003 Parameter OFFW, default 8, branch offset width (OFFW <= PCW).
REQ-004 Parameter CTW, default 16, counter width.
REQ-005 Ports, one per line, SHALL be:
 CLK  in  1  single clock, posedge.
 reset_n  in  1  asynchronous, active-low reset.
 start  in  1  synchronous restart from PC 0, active high.
 imem_addr  out  PCW  instruction fetch address.
 imem_rdata  in  IW  instruction word.
 imem_valid  in  1  imem_rdata valid for imem_addr.
 is_mem  in  1  decoder: latched instruction is a data-memory access.
 branch_en  in  1  decoder: take branch.
 bsign  in  1  branch direction, 1 = backward.
 boffset  in  OFFW  unsigned branch magnitude.
 halt_req  in  1  decoder: latched instruction is halt.
 dmem_req  out  1  data-memory request.
 dmem_ack  in  1  data-memory completion.
 inst  out  IW  latched instruction.
 ex_valid  out  1  one-cycle retire strobe; gates register-file write.
 halt  out  1  done flag.
 fault  out  1  data-memory watchdog expiry.
 cycle_ct  out  CTW  active-cycle count.
 retire_ct  out  CTW  retired-instruction count.

Function
REQ-006 States SHALL be IDLE, FETCH, EXEC, MEM, HALT; FETCH drives imem_addr = PC.
REQ-007 IDLE: wait; start -> FETCH.
REQ-008 FETCH: imem_valid=1 -> latch imem_rdata into inst, -> EXEC; else remain.
REQ-009 EXEC: priority halt_req > is_mem > branch_en > sequential.
REQ-010 EXEC with halt_req: ex_valid=1 that cycle, PC unchanged, -> HALT.
REQ-011 EXEC with is_mem: dmem_req=1 from the next cycle, -> MEM; branch_en ignored.
REQ-012 EXEC otherwise: ex_valid=1; PC <= branch_en ? (bsign ? PC-boffset : PC+boffset) : PC+1; -> FETCH.
REQ-013 boffset SHALL zero-extend to PCW; all PC arithmetic modulo 2^PCW (PC max + 1 = 0, 0 - 1 = max), no flag.
REQ-014 MEM: dmem_req held high until the cycle dmem_ack=1; that cycle ex_valid=1, PC <= PC+1, -> FETCH, dmem_req low next cycle.
REQ-015 dmem_ack outside MEM SHALL be ignored.
REQ-016 HALT: halt=1; remain until start.
REQ-017 start in any state SHALL win over all other inputs: next cycle state FETCH, PC=0, halt=0, fault=0, dmem_req=0, both counters 0.
REQ-018 cycle_ct SHALL increment each cycle in FETCH, EXEC or MEM, saturating at 2^CTW-1.
REQ-019 retire_ct SHALL increment on each ex_valid, saturating at 2^CTW-1.
REQ-020 ex_valid SHALL never be high in two consecutive cycles.

Reset
REQ-021 reset_n=0 SHALL asynchronously force state IDLE, PC=0, inst=0, halt=0, fault=0, dmem_req=0, ex_valid=0, cycle_ct=0, retire_ct=0.
REQ-022 Reset mid-MEM SHALL drop dmem_req immediately, without waiting for the clock.

Configuration
REQ-023 Macro CORE_SEQ_WDOG_EN defined: parameter WDOG_MAX (default 15); MEM lasting WDOG_MAX cycles without dmem_ack SHALL set fault=1, drop dmem_req, -> HALT (no ex_valid).
REQ-024 Macro CORE_SEQ_WDOG_EN undefined: no watchdog logic; fault tied 0; MEM waits indefinitely.

Structure
REQ-025 Package definitions SHALL hold the state enum typedef and default PCW/IW/OFFW/CTW constants.
REQ-026 Sub-module core_pc SHALL hold the PC register and next-PC mux/adder.

Verification
REQ-027 reset_n low, then start pulse, imem_valid=1, non-mem non-branch words -> imem_addr 0,1,2 on successive FETCH; ex_valid every 2nd cycle.
REQ-028 PC=5, branch_en=1, bsign=1, boffset=7, PCW=10 -> next imem_addr=1022; bsign=0, boffset=3 from PC=1022 -> 1.
REQ-029 is_mem=1, branch_en=1, dmem_ack after 3 cycles -> dmem_req high exactly 3 cycles, ex_valid on the ack cycle, next PC = old PC+1.
REQ-030 halt_req at 4th retired instruction -> halt=1, retire_ct=4, cycle_ct frozen while halted; start -> halt=0, counters 0, imem_addr=0.
REQ-031 With CORE_SEQ_WDOG_EN, WDOG_MAX=15, dmem_ack held 0 -> fault=1 and halt=1 after 15 MEM cycles, retire_ct unchanged.
REQ-032 start asserted in MEM with dmem_req=1 -> dmem_req=0 and state FETCH at PC 0 next cycle; late dmem_ack ignored.

Source files
------------

// File: rtl/core_seq_pkg.sv
// Shared types and default sizing for the core_seq sequencer slice.
package core_seq_pkg;

    localparam int DEF_PCW      = 10;
    localparam int DEF_IW       = 9;
    localparam int DEF_OFFW     = 8;
    localparam int DEF_CTW      = 16;
    localparam int DEF_WDOG_MAX = 15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

endpackage

// File: rtl/core_seq_pc.sv
// Program counter register with next-PC mux: clear, sequential step, or
// signed-direction branch by an unsigned magnitude, all modulo 2^PCW.
module core_pc #(
    parameter int PCW  = 10,
    parameter int OFFW = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic            adv_i,
    input  logic            branch_i,
    input  logic            bsign_i,
    input  logic [OFFW-1:0] boffset_i,
    output logic [PCW-1:0]  pc_o
);

    logic [PCW-1:0] pc_q, pc_d;
    logic [PCW-1:0] off_ext;

    assign off_ext = PCW'(boffset_i);

    always_comb begin
        pc_d = pc_q;
        if (clear_i) begin
            pc_d = '0;
        end else if (adv_i) begin
            if (branch_i) begin
                pc_d = bsign_i ? (pc_q - off_ext) : (pc_q + off_ext);
            end else begin
                pc_d = pc_q + PCW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/core_seq.sv
// Fetch/execute/memory sequencer with retire and cycle counters.
// Define CORE_SEQ_WDOG_EN to add the data-memory watchdog (WDOG_MAX cycles).
module core_seq
    import core_seq_pkg::*;
#(
    parameter int PCW      = DEF_PCW,
    parameter int IW       = DEF_IW,
    parameter int OFFW     = DEF_OFFW,
    parameter int CTW      = DEF_CTW
`ifdef CORE_SEQ_WDOG_EN
    ,
    parameter int WDOG_MAX = DEF_WDOG_MAX
`endif
) (
    input  logic            CLK,
    input  logic            reset_n,
    input  logic            start,
    output logic [PCW-1:0]  imem_addr,
    input  logic [IW-1:0]   imem_rdata,
    input  logic            imem_valid,
    input  logic            is_mem,
    input  logic            branch_en,
    input  logic            bsign,
    input  logic [OFFW-1:0] boffset,
    input  logic            halt_req,
    output logic            dmem_req,
    input  logic            dmem_ack,
    output logic [IW-1:0]   inst,
    output logic            ex_valid,
    output logic            halt,
    output logic            fault,
    output logic [CTW-1:0]  cycle_ct,
    output logic [CTW-1:0]  retire_ct
);

    state_e         state_q, state_d;
    logic [IW-1:0]  inst_q, inst_d;
    logic [CTW-1:0] cycle_q, cycle_d;
    logic [CTW-1:0] retire_q, retire_d;
    logic [PCW-1:0] pc;
    logic           ex_valid_c;
    logic           pc_adv;
    logic           pc_branch;
    logic           wdog_expire;
    logic           active;

    core_pc #(
        .PCW  (PCW),
        .OFFW (OFFW)
    ) u_pc (
        .clk_i     (CLK),
        .rst_ni    (reset_n),
        .clear_i   (start),
        .adv_i     (pc_adv),
        .branch_i  (pc_branch),
        .bsign_i   (bsign),
        .boffset_i (boffset),
        .pc_o      (pc)
    );

`ifdef CORE_SEQ_WDOG_EN
    localparam int WDW = (WDOG_MAX > 1) ? $clog2(WDOG_MAX) : 1;

    logic [WDW-1:0] wdog_q, wdog_d;
    logic           fault_q, fault_d;

    assign wdog_expire = (wdog_q == WDW'(WDOG_MAX - 1));

    always_comb begin
        wdog_d  = (state_q == ST_MEM) ? (wdog_q + WDW'(1)) : '0;
        fault_d = fault_q;
        if (start) begin
            fault_d = 1'b0;
        end else if (state_q == ST_MEM && !dmem_ack && wdog_expire) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            wdog_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            wdog_q  <= wdog_d;
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    assign wdog_expire = 1'b0;
    assign fault       = 1'b0;
`endif

    // start overrides every state decision, including a pending retire
    always_comb begin
        state_d    = state_q;
        ex_valid_c = 1'b0;
        pc_adv     = 1'b0;
        pc_branch  = 1'b0;
        unique case (state_q)
            ST_IDLE: ;
            ST_FETCH: begin
                if (imem_valid) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (halt_req) begin
                    ex_valid_c = 1'b1;
                    state_d    = ST_HALT;
                end else if (is_mem) begin
                    state_d = ST_MEM;
                end else begin
                    ex_valid_c = 1'b1;
                    pc_adv     = 1'b1;
                    pc_branch  = branch_en;
                    state_d    = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    ex_valid_c = 1'b1;
                    pc_adv     = 1'b1;
                    state_d    = ST_FETCH;
                end else if (wdog_expire) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: ;
            default: state_d = ST_IDLE;
        endcase
        if (start) begin
            state_d    = ST_FETCH;
            ex_valid_c = 1'b0;
            pc_adv     = 1'b0;
            pc_branch  = 1'b0;
        end
    end

    assign active = (state_q == ST_FETCH) || (state_q == ST_EXEC) || (state_q == ST_MEM);

    always_comb begin
        inst_d   = inst_q;
        cycle_d  = cycle_q;
        retire_d = retire_q;
        if (!start && state_q == ST_FETCH && imem_valid) begin
            inst_d = imem_rdata;
        end
        if (start) begin
            cycle_d  = '0;
            retire_d = '0;
        end else begin
            if (active && cycle_q != '1) cycle_d = cycle_q + CTW'(1);
            if (ex_valid_c && retire_q != '1) retire_d = retire_q + CTW'(1);
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            inst_q   <= '0;
            cycle_q  <= '0;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            inst_q   <= inst_d;
            cycle_q  <= cycle_d;
            retire_q <= retire_d;
        end
    end

    // dmem_req follows MEM residency, so reset drops it asynchronously
    assign dmem_req  = (state_q == ST_MEM);
    assign halt      = (state_q == ST_HALT);
    assign imem_addr = pc;
    assign inst      = inst_q;
    assign ex_valid  = ex_valid_c;
    assign cycle_ct  = cycle_q;
    assign retire_ct = retire_q;

endmodule
